// File: rtl/solver_pkg.sv
// Shared encodings for the solver dispatcher: per-solver state, dispatcher FSM
// state, iteration-count width and the registered result record.
package solver_pkg;
  localparam int ITER_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_LOAD  = 2'd1;
  localparam logic [1:0] D_START = 2'd2;

  typedef struct packed {
    logic [15:0]       id;
    logic [ITER_W-1:0] iter;
  } res_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last
// advanced grant; the pointer moves only when adv_i accepts a grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              ptr_q <= '0;
    else if (adv_i && found) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/solver_dispatch.sv
// Dispatches multi-beat c-limb jobs to a pool of solver cores and returns their
// iteration counts. Optional SOLVER_DISPATCH_PERF_EN adds perf_jobs/perf_busy.
module solver_dispatch
  import solver_pkg::*;
#(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [LIMB_INDEX_BITS-1:0]    cfg_num_limbs,
  input  logic [15:0]                   cfg_iter_lim,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [15:0]                   job_id,
  input  logic [LIMB_BITS-1:0]          job_re,
  input  logic [LIMB_BITS-1:0]          job_im,
  output logic [NUM_SOLVERS-1:0]        s_wr_en,
  output logic [LIMB_INDEX_BITS-1:0]    s_wr_ind,
  output logic [LIMB_BITS-1:0]          s_wr_re,
  output logic [LIMB_BITS-1:0]          s_wr_im,
  output logic                          s_cfg_en,
  output logic [LIMB_INDEX_BITS-1:0]    s_num_limbs,
  output logic [15:0]                   s_iter_lim,
  output logic [NUM_SOLVERS-1:0]        s_start,
  input  logic [NUM_SOLVERS-1:0]        s_out_ready,
  input  logic [ITER_W*NUM_SOLVERS-1:0] s_iter_count,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [15:0]                   res_id,
  output logic [ITER_W-1:0]             res_iter
`ifdef SOLVER_DISPATCH_PERF_EN
  ,
  output logic [31:0]                   perf_jobs,
  output logic [31:0]                   perf_busy
`endif
);
  localparam int N = NUM_SOLVERS;

  logic [N-1:0][1:0]        st_q, st_d;
  logic [N-1:0][15:0]       tag_q, tag_d;
  logic [N-1:0][ITER_W-1:0] iter_q, iter_d;
  logic [1:0]               dst_q, dst_d;
  logic [N-1:0]             sel_q, sel_d, rsel_q, rsel_d;
  logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d, nl_q, nl_d, snl_q;
  logic [15:0]              id_q, id_d, sil_q;
  logic                     cfg_en_q, res_vld_q, res_vld_d;
  res_t                     res_q, res_d;

  logic [N-1:0] idle_v, done_v, alloc_gnt, res_req, res_gnt;
  logic         cfg_acc, alloc, beat, res_hs, res_load;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      idle_v[i] = (st_q[i] == S_IDLE);
      done_v[i] = (st_q[i] == S_DONE);
    end
  end

  // Config wins over a pending job so a reconfiguration cannot be starved.
  assign cfg_acc   = reset && cfg_valid && (dst_q == D_IDLE) && (&idle_v);
  assign cfg_ready = cfg_acc;
  assign alloc     = (dst_q == D_IDLE) && job_valid && !cfg_acc && (|idle_v);
  assign job_ready = (dst_q == D_LOAD);
  assign beat      = job_valid && job_ready;

  assign s_wr_en  = beat ? sel_q  : '0;
  assign s_wr_ind = beat ? cnt_q  : '0;
  assign s_wr_re  = beat ? job_re : '0;
  assign s_wr_im  = beat ? job_im : '0;
  assign s_start  = (dst_q == D_START) ? sel_q : '0;

  assign s_cfg_en    = cfg_en_q;
  assign s_num_limbs = snl_q;
  assign s_iter_lim  = sil_q;

  // The solver currently presented on res_* is masked so the next result can
  // be loaded in the same cycle as the handshake.
  assign res_hs   = res_vld_q && res_ready;
  assign res_load = !res_vld_q || res_ready;
  assign res_req  = done_v & ~(res_vld_q ? rsel_q : '0);

  rr_arbiter #(.N(N)) u_alloc_arb (
    .clock (clock), .reset (reset), .req_i (idle_v), .adv_i (alloc), .gnt_o (alloc_gnt)
  );

  rr_arbiter #(.N(N)) u_res_arb (
    .clock (clock), .reset (reset), .req_i (res_req), .adv_i (res_load), .gnt_o (res_gnt)
  );

  always_comb begin
    dst_d = dst_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    id_d  = id_q;
    nl_d  = cfg_acc ? cfg_num_limbs : nl_q;
    case (dst_q)
      D_IDLE: if (alloc) begin
        dst_d = D_LOAD;
        sel_d = alloc_gnt;
        cnt_d = '0;
      end
      D_LOAD: if (beat) begin
        if (cnt_q == '0) id_d = job_id;
        cnt_d = cnt_q + LIMB_INDEX_BITS'(1);
        if (cnt_q == nl_q) dst_d = D_START;
      end
      D_START: dst_d = D_IDLE;
      default: dst_d = D_IDLE;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    tag_d  = tag_q;
    iter_d = iter_q;
    for (int i = 0; i < N; i++) begin
      case (st_q[i])
        S_IDLE: if (alloc && alloc_gnt[i]) st_d[i] = S_LOAD;
        S_LOAD: if (dst_q == D_START && sel_q[i]) begin
          st_d[i]  = S_RUN;
          tag_d[i] = id_q;
        end
        S_RUN: if (s_out_ready[i]) begin
          st_d[i]   = S_DONE;
          iter_d[i] = s_iter_count[ITER_W*i +: ITER_W];
        end
        S_DONE: if (res_hs && rsel_q[i]) st_d[i] = S_IDLE;
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    res_vld_d = res_vld_q;
    res_d     = res_q;
    rsel_d    = rsel_q;
    if (res_load) begin
      res_vld_d = |res_gnt;
      if (|res_gnt) begin
        rsel_d = res_gnt;
        for (int i = 0; i < N; i++)
          if (res_gnt[i]) res_d = {tag_q[i], iter_q[i]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q      <= '0;
      tag_q     <= '0;
      iter_q    <= '0;
      dst_q     <= D_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      nl_q      <= '0;
      cfg_en_q  <= 1'b0;
      snl_q     <= '0;
      sil_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      rsel_q    <= '0;
    end else begin
      st_q      <= st_d;
      tag_q     <= tag_d;
      iter_q    <= iter_d;
      dst_q     <= dst_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      nl_q      <= nl_d;
      cfg_en_q  <= cfg_acc;
      if (cfg_acc) begin
        snl_q <= cfg_num_limbs;
        sil_q <= cfg_iter_lim;
      end
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      rsel_q    <= rsel_d;
    end
  end

  assign res_valid = res_vld_q;
  assign res_id    = res_q.id;
  assign res_iter  = res_q.iter;

`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0] pj_q, pb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pj_q <= '0;
      pb_q <= '0;
    end else begin
      if (res_hs && !(&pj_q))      pj_q <= pj_q + 32'd1;
      if (!(&idle_v) && !(&pb_q))  pb_q <= pb_q + 32'd1;
    end
  end

  assign perf_jobs = pj_q;
  assign perf_busy = pb_q;
`endif
endmodule

// File: doc/solver_dispatch.md
SOLVER_DISPATCH -- requirements
Module: solver_dispatch

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 4: number of attached solver cores (2..8).
REQ-002 SHALL have parameter LIMB_INDEX_BITS, default 6: limb index width, matching the solver cores.
REQ-003 SHALL have parameter LIMB_BITS, default 32: width of one c limb.
REQ-004 SHALL have port clock  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  in  1  host configuration request.
REQ-007 SHALL have port cfg_ready  out  1  configuration accepted this cycle.
REQ-008 SHALL have port cfg_num_limbs  in  LIMB_INDEX_BITS  highest limb index per job.
REQ-009 SHALL have port cfg_iter_lim  in  16  iteration limit.
REQ-010 SHALL have port job_valid  in  1  job beat valid.
REQ-011 SHALL have port job_ready  out  1  job beat accepted.
REQ-012 SHALL have port job_id  in  16  job tag, sampled on the first beat.
REQ-013 SHALL have port job_re  in  LIMB_BITS  real limb of c, beat k = limb k.
REQ-014 SHALL have port job_im  in  LIMB_BITS  imaginary limb of c, beat k = limb k.
REQ-015 SHALL have port s_wr_en  out  NUM_SOLVERS  one-hot real+imag limb write strobe.
REQ-016 SHALL have port s_wr_ind  out  LIMB_INDEX_BITS  shared limb write index.
REQ-017 SHALL have port s_wr_re / s_wr_im  out  LIMB_BITS each  shared limb data.
REQ-018 SHALL have port s_cfg_en  out  1  broadcast num_limbs and iteration-limit write strobe.
REQ-019 SHALL have port s_num_limbs  out  LIMB_INDEX_BITS  and port s_iter_lim  out  16  broadcast config data.
REQ-020 SHALL have port s_start  out  NUM_SOLVERS  one-hot single-cycle start pulse.
REQ-021 SHALL have port s_out_ready  in  NUM_SOLVERS  per-solver done level.
REQ-022 SHALL have port s_iter_count  in  16*NUM_SOLVERS  per-solver result, solver i at bits [16i+15:16i].
REQ-023 SHALL have port res_valid  out  1  and port res_ready  in  1  result handshake.
REQ-024 SHALL have port res_id  out  16  and port res_iter  out  16  result tag and iteration count.

Function
REQ-025 Per-solver state SHALL be IDLE, LOAD, RUN or DONE; the dispatcher FSM SHALL be D_IDLE, D_LOAD or D_START.
REQ-026 D_IDLE with any IDLE solver SHALL select one round-robin (from last grant+1), mark it LOAD, and go to D_LOAD the next cycle.
REQ-027 In D_LOAD, job_ready=1; each accepted beat SHALL assert s_wr_en[sel] combinationally with s_wr_ind=beat counter, then increment the counter.
REQ-028 The beat with index==num_limbs SHALL end the load and go to D_START; a job is exactly num_limbs+1 beats.
REQ-029 D_START SHALL pulse s_start[sel] for 1 cycle, latch job_id into the solver's tag, mark the solver RUN, and return to D_IDLE.
REQ-030 s_out_ready SHALL be ignored in the s_start cycle; RUN→DONE on the first later cycle with s_out_ready=1.
REQ-031 Result arbitration SHALL be round-robin over DONE solvers and independent of the load path; res_* SHALL be registered and held stable until res_ready.
REQ-032 A solver whose result handshake completes SHALL become IDLE the next cycle and be allocatable no earlier than that.
REQ-033 cfg_ready SHALL equal cfg_valid while D_IDLE with all solvers IDLE; on acceptance, s_cfg_en=1 for 1 cycle and the internal num_limbs copy updates.
REQ-034 With no IDLE solver, job_ready SHALL stay 0; with no DONE solver, res_valid SHALL stay 0.

Reset
REQ-035 On reset=0: all solvers IDLE, FSM D_IDLE, round-robin pointers 0, num_limbs 0; every output 0 (job_ready, cfg_ready, res_valid, strobes, res_*, s_*). In-flight jobs SHALL be dropped.

Configuration
REQ-036 Macro SOLVER_DISPATCH_PERF_EN defined: SHALL add outputs perf_jobs[31:0] (completed result handshakes) and perf_busy[31:0] (cycles with any solver non-IDLE), both saturating and reset to 0. Undefined: neither port nor counter SHALL exist.

Structure
REQ-037 Shared package solver_pkg SHALL hold the solver-state and dispatcher-state encodings and the iteration-count width constant.
REQ-038 Sub-module rr_arbiter (request vector, advance, one-hot grant) SHALL be instantiated twice: allocation and results.

Verification
REQ-039 num_limbs=2, one job id=0x0011, 3 beats → s_wr_en=0001 at indices 0,1,2; s_start=0001 one cycle later.
REQ-040 Solver 0 raises out_ready with iter_count=37 → res_valid, res_id=0x0011, res_iter=37; after res_ready, solver 0 is IDLE.
REQ-041 Five back-to-back jobs, 4 solvers all RUN → job_ready=0 until the first result is accepted, then job 5 goes to the freed solver.
REQ-042 Solvers 1 and 3 finish in the same cycle, res_ready=1 → results from 1 then 3 on consecutive handshakes.
REQ-043 cfg_valid while any solver RUN → cfg_ready=0; once all are IDLE → one s_cfg_en pulse with the new data.
REQ-044 reset=0 mid-D_LOAD → all outputs 0 immediately; after release, a new job loads from index 0 into solver 0.
